// File: rtl/uart_rx_if.sv
// uart_rx_if: receive-side byte handshake between uart_rx and the keyboard
// I/O logic.
//   master (uart_rx) drives : rx_data, rx_valid, rx_frame_err, rx_overrun,
//                             rx_busy, rx_parity_err (only with UARTRX_PARITY_EN)
//   slave  (consumer) drives: rx_read (single-cycle consume strobe)
// Optional feature macro: UARTRX_PARITY_EN adds rx_parity_err.
`timescale 1ns/1ps
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_read;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;
`ifdef UARTRX_PARITY_EN
  logic       rx_parity_err;
`endif

  modport master (
    input  rx_read,
    output rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
`ifdef UARTRX_PARITY_EN
    , rx_parity_err
`endif
  );

  modport slave (
    output rx_read,
    input  rx_data, rx_valid, rx_frame_err, rx_overrun, rx_busy
`ifdef UARTRX_PARITY_EN
    , rx_parity_err
`endif
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 8N1, LSB first.
// Ports:
//   clk   - system clock, all state on posedge
//   nrst  - asynchronous active-low reset
//   rx    - serial line, idle high, asynchronous to clk
//   bus   - uart_rx_if.master: rx_data/rx_valid byte hold with rx_read
//           consume strobe, sticky rx_frame_err/rx_overrun, rx_busy
// Parameters: CLKS_PER_BIT (4..65535), CNT_W (>= clog2(CLKS_PER_BIT)),
//   ODD_PARITY (only with the macro).
// Optional feature macro: UARTRX_PARITY_EN inserts a parity bit between the
//   data bits and the stop bit and drives bus.rx_parity_err.
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
`ifdef UARTRX_PARITY_EN
  , parameter bit ODD_PARITY = 1'b0
`endif
) (
  input  logic     clk,
  input  logic     nrst,
  input  logic     rx,
  uart_rx_if.master bus
);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UARTRX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t           state_reg;
  logic             sync_reg;     // first synchronizer stage
  logic             rs_reg;       // synchronized line value
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       idx_reg;
  logic [7:0]       shift_reg;
  logic             commit_reg;   // byte complete, publish next edge
  logic             ferr_pend_reg;
  logic [7:0]       data_reg;
  logic             valid_reg;
  logic             ferr_reg;
  logic             ovr_reg;
  logic             busy_reg;
`ifdef UARTRX_PARITY_EN
  logic             par_bit_reg;
  logic             perr_reg;
  assign bus.rx_parity_err = perr_reg;
`endif

  assign bus.rx_data      = data_reg;
  assign bus.rx_valid     = valid_reg;
  assign bus.rx_frame_err = ferr_reg;
  assign bus.rx_overrun   = ovr_reg;
  assign bus.rx_busy      = busy_reg;

  // A consume only counts while a byte is actually held.
  logic read_ack;
  assign read_ack = bus.rx_read & valid_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg     <= IDLE;
      sync_reg      <= 1'b1;
      rs_reg        <= 1'b1;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      commit_reg    <= 1'b0;
      ferr_pend_reg <= 1'b0;
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      ferr_reg      <= 1'b0;
      ovr_reg       <= 1'b0;
      busy_reg      <= 1'b0;
`ifdef UARTRX_PARITY_EN
      par_bit_reg   <= 1'b0;
      perr_reg      <= 1'b0;
`endif
    end else begin
      sync_reg   <= rx;
      rs_reg     <= sync_reg;
      commit_reg <= 1'b0;

      // Commit beats a simultaneous read: the new byte stays valid, flags
      // from the consumed byte are dropped, and no overrun is raised.
      if (commit_reg) begin
        data_reg  <= shift_reg;
        valid_reg <= 1'b1;
        ovr_reg   <= (ovr_reg & ~read_ack) | (valid_reg & ~bus.rx_read);
        ferr_reg  <= (ferr_reg & ~read_ack) | ferr_pend_reg;
`ifdef UARTRX_PARITY_EN
        perr_reg  <= (perr_reg & ~read_ack) |
                     (par_bit_reg ^ (^shift_reg) ^ ODD_PARITY);
`endif
      end else if (read_ack) begin
        valid_reg <= 1'b0;
        ferr_reg  <= 1'b0;
        ovr_reg   <= 1'b0;
`ifdef UARTRX_PARITY_EN
        perr_reg  <= 1'b0;
`endif
      end

      case (state_reg)
        IDLE: begin
          if (!rs_reg) begin
            state_reg <= START;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            if (rs_reg) begin
              // Line went back high before mid-bit: glitch, not a frame.
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= DATA;
              idx_reg   <= '0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg            <= '0;
            shift_reg[idx_reg] <= rs_reg;
            if (idx_reg == 3'd7) begin
`ifdef UARTRX_PARITY_EN
              state_reg <= PARITY;
`else
              state_reg <= STOP;
`endif
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`ifdef UARTRX_PARITY_EN
        PARITY: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg     <= '0;
            par_bit_reg <= rs_reg;
            state_reg   <= STOP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg       <= '0;
            commit_reg    <= 1'b1;
            ferr_pend_reg <= ~rs_reg;
            if (rs_reg) begin
              // Back to IDLE mid stop bit so a back-to-back start is caught.
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= BREAK;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        BREAK: begin
          // A held-low line must not be decoded as a stream of 0x00 frames.
          if (rs_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 framing, LSB first. It is the receive-side counterpart of the existing uart_tx block.
- Converts the serial `rx` line into bytes, presented on a level-held valid/acknowledge handshake toward the PDP-8 I/O logic (keyboard device).
- Flags framing errors and overruns.
- A bench can loop `uart_tx.tx` into `rx` for end-to-end checks.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit period (50 MHz / 115200). Legal range 4..65535.
- CNT_W, 16, width of the bit-period counter. Must satisfy CNT_W ≥ clog2(CLKS_PER_BIT).

Ports:
- clk  input  1  system clock; all state on posedge.
- nrst  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  received byte; valid while rx_valid=1.
- rx_valid  output  1  byte available; held until consumed.
- rx_read  input  1  single-cycle consume strobe; clears rx_valid.
- rx_frame_err  output  1  sticky: stop bit sampled 0; cleared by rx_read.
- rx_overrun  output  1  sticky: byte completed while rx_valid=1; cleared by rx_read.
- rx_busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- **Reset** (nrst=0, async): FSM=IDLE, counters=0, rx_data=8'h00, and rx_valid, rx_frame_err, rx_overrun, rx_busy all 0. The synchronizer flops reset to 1 (line idle).
- **Input sync:** `rx` passes through a 2-flop synchronizer. All decisions use the synchronized value rs. Input-to-decision latency is 2 cycles.

FSM states:
- **IDLE:** on rs=0, load counter and go to START.
- **START:** count (CLKS_PER_BIT-1)/2 cycles to the bit middle, then sample rs.
  - rs=1: false start (glitch); return to IDLE with no flags.
  - rs=0: go to DATA, bit index=0.
- **DATA:** every CLKS_PER_BIT cycles, sample rs into shift register position `index` (LSB first). After index 7, go to STOP.
- **STOP:** after CLKS_PER_BIT cycles, sample rs.
  - rs=1: commit the byte; return to IDLE the next cycle. This leaves half a bit period of slack, so back-to-back frames must be received.
  - rs=0: set rx_frame_err and still commit the byte. Go to BREAK.
- **BREAK:** wait until rs=1, then go to IDLE. Prevents a held-low line from generating repeated frames.
- rx_busy=1 in every state except IDLE.

Commit (one cycle after the stop-bit sample):
- rx_data ← shift register.
- rx_valid ← 1.
- If rx_valid was already 1 and rx_read is not asserted in the same cycle: rx_overrun ← 1. The new byte overwrites rx_data (newest wins).

Handshake:
- rx_read with rx_valid=1: rx_valid, rx_frame_err and rx_overrun clear on the next edge.
- rx_read with rx_valid=0: ignored.
- Commit and rx_read in the same cycle: commit wins. rx_valid stays 1 with the new data; no overrun.

Other rules:
- Counter compares use CNT_W-bit unsigned arithmetic. No wrap occurs within the legal range.
- Async reset mid-frame aborts immediately. The remainder of the frame is treated as line noise: a false start or a garbage frame, no lockup.

Optional Feature:
- **With `UARTRX_PARITY_EN` defined:**
  - A PARITY state is inserted between DATA and STOP. It samples one extra bit period.
  - New parameter ODD_PARITY (default 0 = even).
  - New output rx_parity_err (1 bit, sticky). It is set at commit when the received parity mismatches the XOR of rx_data (inverted if ODD_PARITY). It clears with rx_read and resets to 0.
- **Without the macro:** no PARITY state and no rx_parity_err port; 8N1 only.

Test Plan (CLKS_PER_BIT=8 unless stated):
- Send 8'hA5 as valid 8N1 → rx_valid rises 1 cycle after the stop-bit middle (about 9.5 bit times after the start edge plus 2 sync cycles); rx_data=8'hA5; no errors. Pulse rx_read → rx_valid=0.
- Back-to-back 8'h00 then 8'hFF with no idle gap, rx_read pulsed after each → both bytes received in order, no flags.
- Drive rx low for 3 cycles, then high → false start; FSM returns to IDLE; rx_valid stays 0; rx_busy pulses.
- Send 8'h3C with stop bit=0, then hold rx low for 20 bit times → rx_data=8'h3C, rx_valid=1, rx_frame_err=1; exactly one commit. A following valid byte 8'h11 is received after rx returns high.
- Send 8'h12, then 8'h34 without rx_read → rx_data=8'h34, rx_overrun=1. rx_read clears rx_valid and rx_overrun.
- Assert nrst=0 mid-DATA while receiving 8'h55 → all outputs 0 immediately. After release and line idle, 8'h77 is received correctly.
- With UARTRX_PARITY_EN and ODD_PARITY=0: send 8'h07 with parity bit 0 → rx_parity_err=1. Send the same byte with parity bit 1 → rx_parity_err=0.
